// File: rtl/weight_rsp_unit.sv
// Weight SRAM responder: credit-limited word reads from the arbiter, returned address-tagged and in
// acceptance order through a show-ahead response FIFO.
module weight_rsp_unit #(
  parameter int MEM_AW     = 14,
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       req_addr,
  input  logic              req_vld,
  input  logic              req_req,
  output logic              req_rdy,
  output logic [31:0]       rsp_addr,
  output logic [31:0]       rsp_data,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_ren,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              drain_done,
  output logic              oob_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW:0]   PTR_ONE = 1;
  localparam logic [CW-1:0] CRD_ONE = 1;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic                drain_done_q, oob_err_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic                accept, pop, push, empty, full, oob_req;
  logic [31:0]         push_data;

  logic                vld_p0_q, oob_p0_q;
  logic [31:0]         addr_p0_q;
  logic [READ_LAT-1:0] vld_pn_q, oob_pn_q;
  logic [31:0]         addr_pn_q [READ_LAT];

  logic [PW:0]         wr_ptr_q, rd_ptr_q;
  logic [31:0]         fifo_addr_q [FIFO_DEPTH];
  logic [31:0]         fifo_data_q [FIFO_DEPTH];

  assign req_rdy    = (state_q == GRANT) && (credit_q < CW'(FIFO_DEPTH));
  assign accept     = req_vld & req_rdy;
  assign pop        = rsp_vld & rsp_rdy;
  assign oob_req    = |req_addr[31:MEM_AW+2];
  assign busy       = (state_q != IDLE);
  assign drain_done = drain_done_q;
  assign oob_err    = oob_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_ren    = vld_p0_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_req) state_d = GRANT;
      GRANT:   if (!req_req) state_d = DRAIN;
      DRAIN: begin
        if (req_req)              state_d = GRANT;
        else if (credit_q == '0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    if (accept && !pop)      credit_d = credit_q + CRD_ONE;
    else if (!accept && pop) credit_d = credit_q - CRD_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      drain_done_q <= 1'b0;
      oob_err_q    <= 1'b0;
      mem_addr_q   <= '0;
      vld_p0_q     <= 1'b0;
      vld_pn_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      drain_done_q <= (state_q == DRAIN) && (state_d == IDLE);
      if (accept && oob_req) oob_err_q <= 1'b1;
      if (accept) mem_addr_q <= req_addr[MEM_AW+1:2];
      vld_p0_q     <= accept;
      vld_pn_q[0]  <= vld_p0_q;
      for (int i = 1; i < READ_LAT; i++) vld_pn_q[i] <= vld_pn_q[i-1];
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Stage p0: request tag captured alongside the SRAM read issue
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0_q <= req_addr;
      oob_p0_q  <= oob_req;
    end
  end

  // Stages p1..pN: tag rides next to the SRAM read latency
  always_ff @(posedge clk) begin
    addr_pn_q[0] <= addr_p0_q;
    oob_pn_q[0]  <= oob_p0_q;
    for (int i = 1; i < READ_LAT; i++) begin
      addr_pn_q[i] <= addr_pn_q[i-1];
      oob_pn_q[i]  <= oob_pn_q[i-1];
    end
  end

  assign push      = vld_pn_q[READ_LAT-1];
  assign push_data = oob_pn_q[READ_LAT-1] ? 32'h0 : mem_rdata;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // FIFO write: response enters the queue as the SRAM data lands
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q[PW-1:0]] <= addr_pn_q[READ_LAT-1];
      fifo_data_q[wr_ptr_q[PW-1:0]] <= push_data;
    end
  end

  // Head is gated to zero when empty so stale storage never shows after reset
  assign rsp_vld  = !empty;
  assign rsp_addr = empty ? 32'h0 : fifo_addr_q[rd_ptr_q[PW-1:0]];
  assign rsp_data = empty ? 32'h0 : fifo_data_q[rd_ptr_q[PW-1:0]];

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_weight_rsp_unit.sv
// Bench for weight_rsp_unit: SRAM responder model, queue-based reference of accepted reads,
// directed scenarios with literal expectations, then a randomized session.
module tb_weight_rsp_unit;
  localparam int MEM_AW   = 14;
  localparam int READ_LAT = 2;
  localparam int DEPTH    = 8;

  logic              clk = 1'b0;
  logic              rst, req_vld, req_req, req_rdy, rsp_vld, rsp_rdy, mem_ren;
  logic              busy, drain_done, oob_err;
  logic [31:0]       req_addr, rsp_addr, rsp_data, mem_rdata;
  logic [MEM_AW-1:0] mem_addr;

  always #5 clk = ~clk;

  weight_rsp_unit #(.MEM_AW(MEM_AW), .READ_LAT(READ_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_vld(req_vld), .req_req(req_req),
    .req_rdy(req_rdy), .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_vld(rsp_vld),
    .rsp_rdy(rsp_rdy), .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .busy(busy), .drain_done(drain_done), .oob_err(oob_err)
  );

  function automatic logic [31:0] word_of(input logic [MEM_AW-1:0] wa);
    if (wa == 14'h10) return 32'hDEADBEEF;
    return {18'h0, wa} * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction

  // SRAM: fixed latency, garbage on cycles without a read
  logic [31:0] rd_pipe [READ_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_ren ? word_of(mem_addr) : $urandom;
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[READ_LAT-1];

  int checks = 0;
  int failures = 0;
  int pops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: every accepted read in order, with the cycle it must become visible
  typedef struct { logic [31:0] a; logic [31:0] d; int vis; } ent_t;
  ent_t q[$];
  int   sess = 0;      // 0 idle, 1 granted, 2 draining
  int   cyc = 0;
  bit   model_ok = 0;
  bit   m_ren, m_oob, m_dd;
  logic [MEM_AW-1:0] m_addr;

  always @(negedge clk) begin
    bit e_rdy, e_vld, acc, pnow;
    int qs;
    qs    = q.size();
    e_rdy = (sess == 1) && (qs < DEPTH);
    e_vld = 1'b0;
    if (qs > 0) e_vld = (q[0].vis <= cyc);
    if (model_ok) begin
      chk("req_rdy", 32'(req_rdy), 32'(e_rdy));
      chk("rsp_vld", 32'(rsp_vld), 32'(e_vld));
      chk("busy", 32'(busy), 32'(sess != 0));
      chk("drain_done", 32'(drain_done), 32'(m_dd));
      chk("oob_err", 32'(oob_err), 32'(m_oob));
      chk("mem_ren", 32'(mem_ren), 32'(m_ren));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (e_vld) begin
        chk("rsp_addr", rsp_addr, q[0].a);
        chk("rsp_data", rsp_data, q[0].d);
      end
    end
    if (rst) begin
      q.delete();
      sess = 0; m_ren = 0; m_addr = '0; m_oob = 0; m_dd = 0; model_ok = 1;
    end else if (model_ok) begin
      acc  = req_vld && e_rdy;
      pnow = e_vld && rsp_rdy;
      m_dd = (sess == 2) && !req_req && (qs == 0);
      case (sess)
        0: if (req_req) sess = 1;
        1: if (!req_req) sess = 2;
        default: if (req_req) sess = 1; else if (qs == 0) sess = 0;
      endcase
      if (pnow) begin
        void'(q.pop_front());
        pops++;
      end
      if (acc)
        q.push_back('{req_addr,
                      (req_addr[31:MEM_AW+2] != 0) ? 32'h0 : word_of(req_addr[MEM_AW+1:2]),
                      cyc + READ_LAT + 2});
      m_ren = acc;
      if (acc) m_addr = req_addr[MEM_AW+1:2];
      if (acc && req_addr[31:MEM_AW+2] != 0) m_oob = 1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_rdy"}, 32'(req_rdy), 32'h0);
    chk({tag, "_rsp_vld"}, 32'(rsp_vld), 32'h0);
    chk({tag, "_rsp_addr"}, rsp_addr, 32'h0);
    chk({tag, "_rsp_data"}, rsp_data, 32'h0);
    chk({tag, "_mem_ren"}, 32'(mem_ren), 32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_drain_done"}, 32'(drain_done), 32'h0);
    chk({tag, "_oob_err"}, 32'(oob_err), 32'h0);
  endtask

  task automatic send(input logic [31:0] a);
    int n;
    bit ok;
    n = 0; ok = 0;
    req_vld = 1; req_addr = a;
    while (!ok && n < 50) begin
      ok = req_rdy;
      tick();
      n++;
    end
    req_vld = 0;
    chk("send_accept", 32'(ok), 32'h1);
  endtask

  task automatic settle();
    int n;
    n = 0;
    req_req = 0; req_vld = 0; rsp_rdy = 1;
    while ((busy || rsp_vld) && n < 100) begin
      tick();
      n++;
    end
    chk("settle_done", 32'(n < 100), 32'h1);
  endtask

  initial begin
    int n, n2, drops, first, last, p0, ddc, ddbad;
    bit a;
    rst = 1; req_req = 0; req_vld = 0; req_addr = 0; rsp_rdy = 0;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 0;
    tick();

    // Single read of word 0x10
    req_req = 1;
    tick();
    chk("single_rdy", 32'(req_rdy), 32'h1);
    req_vld = 1; req_addr = 32'h40;
    tick();
    req_vld = 0;
    chk("single_mem_ren", 32'(mem_ren), 32'h1);
    chk("single_mem_addr", 32'(mem_addr), 32'h10);
    tick(); tick();
    chk("single_early_vld", 32'(rsp_vld), 32'h0);
    tick();
    chk("single_rsp_vld", 32'(rsp_vld), 32'h1);
    chk("single_rsp_addr", rsp_addr, 32'h40);
    chk("single_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("single_oob", 32'(oob_err), 32'h0);
    rsp_rdy = 1;
    tick();
    settle();

    // Streaming: 144 back-to-back reads
    p0 = pops; n = 0; drops = 0; first = -1; last = 0;
    rsp_rdy = 1; req_req = 1; req_vld = 1; req_addr = 32'h1000;
    for (int c = 0; c < 400 && n < 144; c++) begin
      a = req_rdy;
      if (n > 0 && !req_rdy) drops++;
      tick();
      if (a) begin
        if (first < 0) first = c;
        last = c;
        n++;
        req_addr = 32'h1000 + 32'(4 * n);
      end
    end
    req_vld = 0;
    chk("stream_accepts", 32'(n), 32'd144);
    chk("stream_rdy_drops", 32'(drops), 32'h0);
    chk("stream_span", 32'(last - first + 1), 32'd144);
    settle();
    chk("stream_responses", 32'(pops - p0), 32'd144);

    // Backpressure: credits stop accepts at the FIFO depth
    p0 = pops; n = 0; n2 = 0;
    rsp_rdy = 0; req_req = 1; req_vld = 1; req_addr = 32'h2000;
    for (int c = 0; c < 30; c++) begin
      a = req_rdy;
      tick();
      if (a) begin n++; req_addr = req_addr + 32'h4; end
    end
    chk("bp_accepts", 32'(n), 32'd8);
    chk("bp_rdy_low", 32'(req_rdy), 32'h0);
    rsp_rdy = 1;
    for (int c = 0; c < 30; c++) begin
      a = req_rdy;
      tick();
      if (a) begin n2++; req_addr = req_addr + 32'h4; end
    end
    req_vld = 0;
    chk("bp_resumed", 32'(n2 > 0), 32'h1);
    settle();
    chk("bp_responses", 32'(pops - p0), 32'(8 + n2));

    // Drain with three outstanding
    p0 = pops; ddc = 0; ddbad = 0;
    rsp_rdy = 0; req_req = 1;
    send(32'h0500); send(32'h0504); send(32'h0508);
    req_req = 0;
    repeat (4) tick();
    chk("drain_busy", 32'(busy), 32'h1);
    rsp_rdy = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (drain_done) begin
        ddc++;
        if (busy) ddbad++;
      end
    end
    chk("drain_pulses", 32'(ddc), 32'h1);
    chk("drain_busy_low", 32'(ddbad), 32'h0);
    chk("drain_responses", 32'(pops - p0), 32'd3);

    // Out-of-range address
    rsp_rdy = 0; req_req = 1;
    send(32'h0001_0000);
    n = 0;
    while (!rsp_vld && n < 20) begin tick(); n++; end
    chk("oob_rsp_seen", 32'(rsp_vld), 32'h1);
    chk("oob_rsp_addr", rsp_addr, 32'h0001_0000);
    chk("oob_rsp_data", rsp_data, 32'h0);
    chk("oob_flag", 32'(oob_err), 32'h1);
    rsp_rdy = 1;
    send(32'h0080); send(32'h0084);
    settle();
    chk("oob_sticky", 32'(oob_err), 32'h1);

    // Reset with five reads outstanding
    rsp_rdy = 0; req_req = 1;
    for (int k = 0; k < 5; k++) send(32'h3000 + 32'(4 * k));
    rst = 1; req_req = 0;
    tick();
    chk_reset_vals("midrst");
    rst = 0;
    rsp_rdy = 1;
    repeat (8) tick();
    chk("midrst_no_stale", 32'(rsp_vld), 32'h0);

    // Randomized session
    req_req = 1;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      if ($urandom_range(0, 99) < 3) req_req = !req_req;
      req_vld = $urandom_range(0, 1) != 0;
      rsp_rdy = $urandom_range(0, 3) != 0;
      r = $urandom;
      if ($urandom_range(0, 19) != 0) r[31:16] = 16'h0;
      req_addr = r;
      rst = (c == 1500);
      tick();
    end
    rst = 0;
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
